reg_wb_commit: RTL and testbench
================================

// Module: reg_wb_commit
// PURPOSE
//  Writeback end of the execute-stage write interface. Owns the 32x32 GPR file and the PC register.
//  Accepts GPR write requests (reg_w_*) and PC redirects (reg_pc_w_*) from the exec units, e.g. JALR.
//  GPR writes are buffered in a small FIFO and committed one per cycle.
//  Read ports bypass pending FIFO entries, so decode always sees the newest value.
// PARAMETERS
//  DEPTH     4             GPR write FIFO entries; power of 2, >= 2
//  RESET_PC  32'h00000000  PC value loaded on reset
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst_n          in   1   reset, asynchronous, active-low
//  reg_w_op       in   1   GPR write request valid
//  reg_w_reg_idx  in   5   GPR write index
//  reg_w_reg_val  in   32  GPR write data
//  reg_pc_w_op    in   1   PC redirect valid
//  reg_pc_w_val   in   32  PC redirect target
//  pc_adv         in   1   sequential advance, PC += 4
//  wb_hold        in   1   freeze FIFO drain; enqueue still allowed
//  wb_ready       out  1   FIFO not full; combinational from state only
//  reg_rs1        in   5   read port 1 index
//  reg_rs2        in   5   read port 2 index
//  reg_rs1_val    out  32  read port 1 data
//  reg_rs2_val    out  32  read port 2 data
//  reg_pc_val     out  32  current PC
//  wb_busy        out  1   FIFO non-empty
//  wb_overflow    out  1   sticky; a request was dropped while full
//  pc_misalign    out  1   1-cycle pulse; committed redirect had bit1 set
// BEHAVIOUR
//  Reset (async, while rst_n=0):
//   - GPRs = 0; PC = RESET_PC; FIFO empty, pointers and count = 0.
//   - wb_overflow = 0; pc_misalign = 0.
//   - Reset mid-operation discards pending FIFO entries without committing them.
//  Enqueue:
//   - On an edge with reg_w_op=1 and wb_ready=1, push {idx,val}.
//   - idx==0 is accepted but not pushed; x0 is never written.
//   - wb_ready = (count != DEPTH). A full FIFO refuses even if it drains the same cycle.
//   - reg_w_op=1 with wb_ready=0: request dropped, wb_overflow set until reset.
//  Drain:
//   - Each edge with wb_hold=0 and count!=0: pop the head, write it to the GPR file.
//   - A push and a pop on the same edge leave count unchanged.
//   - Pointers wrap modulo DEPTH.
//   - Commit latency: a value enqueued at edge N is in the GPR file after edge N+1 (wb_hold=0, FIFO was empty).
//  Reads (combinational from registered state only, no path from reg_w_* inputs):
//   - idx 0 -> 0.
//   - Otherwise the youngest FIFO entry matching idx, if any; else the GPR file.
//   - Bypass must scan all DEPTH slots and handle wrap-around ordering.
//  PC (independent of wb_hold and of FIFO state):
//   - reg_pc_w_op=1: PC <= {reg_pc_w_val[31:1],1'b0}; pc_misalign <= reg_pc_w_val[1].
//   - else pc_adv=1: PC <= PC+4, mod 2^32 so 32'hFFFFFFFC wraps to 0; pc_misalign <= 0.
//   - else hold PC; pc_misalign <= 0.
//   - Redirect has priority when reg_pc_w_op and pc_adv are both set.
//   - The redirect still updates PC when misaligned; pc_misalign is report only.
//  Same-edge GPR request and PC redirect (the JALR case): both take effect independently.
//  wb_busy = (count != 0).
// TESTING
//  1. Reset: rst_n low -> PC=RESET_PC, reg_rs1_val=0 for all idx, wb_ready=1, wb_busy=0, flags 0.
//  2. JALR edge: reg_w_op=1, idx=1, val=0x104, reg_pc_w_op=1, target=0x201
//     -> PC=0x200 next cycle; rs1=1 reads 0x104 via bypass, then from the GPR file; pc_misalign=0.
//  3. wb_hold=1, push idx5=0xA then idx5=0xB
//     -> rs1=5 reads 0xB; after DEPTH pushes wb_ready=0;
//     -> a further push sets wb_overflow=1 and the GPR file is unchanged;
//     -> release wb_hold -> drains in order, final x5=0xB.
//  4. Push idx0=0xFFFF -> FIFO count unchanged, x0 reads 0.
//  5. PC=0xFFFFFFFC, pc_adv=1 -> PC=0; then redirect 0x6 -> PC=0x6, pc_misalign pulses 1 cycle.
//  6. Assert rst_n=0 asynchronously with 3 entries pending
//     -> FIFO empty immediately, entries never committed, GPRs=0.

Source files
------------

// File: rtl/reg_wb_commit.sv
// Purpose : writeback commit stage; owns the 32x32 GPR file and the PC, and buffers GPR writes in a FIFO.
// Latency : a write accepted on edge N reaches the GPR file on edge N+1 when the FIFO was empty and wb_hold=0.
//           Reads bypass pending entries, so a value is readable from the cycle after it is accepted.
// Backpr. : wb_ready=0 when the FIFO is full; a request offered while full is dropped and sets sticky wb_overflow.
//
// Ports:
//   clk, rst_n                   clock (posedge) and asynchronous active-low reset
//   reg_w_op/_reg_idx/_reg_val   GPR write request (idx 0 is accepted and discarded)
//   reg_pc_w_op/reg_pc_w_val     PC redirect; bit 0 of the target is cleared
//   pc_adv                       sequential PC += 4 when no redirect is present
//   wb_hold                      freezes FIFO drain; enqueue still allowed
//   wb_ready, wb_busy            FIFO not full / FIFO not empty
//   reg_rs1/2 -> reg_rs1/2_val   combinational read ports with FIFO bypass
//   reg_pc_val                   current PC
//   wb_overflow                  sticky drop indicator, cleared only by reset
//   pc_misalign                  one-cycle pulse when a committed redirect had bit 1 set
module reg_wb_commit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_w_op,
  input  logic [4:0]  reg_w_reg_idx,
  input  logic [31:0] reg_w_reg_val,
  input  logic        reg_pc_w_op,
  input  logic [31:0] reg_pc_w_val,
  input  logic        pc_adv,
  input  logic        wb_hold,
  output logic        wb_ready,
  input  logic [4:0]  reg_rs1,
  input  logic [4:0]  reg_rs2,
  output logic [31:0] reg_rs1_val,
  output logic [31:0] reg_rs2_val,
  output logic [31:0] reg_pc_val,
  output logic        wb_busy,
  output logic        wb_overflow,
  output logic        pc_misalign
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Write FIFO storage and control
  // ---------------------------------------------------------------------------
  logic [4:0]    fifo_idx [DEPTH];
  logic [31:0]   fifo_val [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          push;
  logic          pop;
  logic          drop;

  // Ready depends on registered count only, so a full FIFO refuses a new
  // request even on an edge where it also drains.
  assign wb_ready = (count != FULL_CNT);
  assign wb_busy  = (count != '0);

  // x0 writes are acknowledged (no drop) but never occupy a slot.
  assign push = reg_w_op && wb_ready && (reg_w_reg_idx != 5'd0);
  assign drop = reg_w_op && !wb_ready;
  assign pop  = !wb_hold && wb_busy;

  // Payload slots need no reset: a slot is only observed while it lies
  // inside the [rd_ptr, rd_ptr+count) window.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= reg_w_reg_idx;
      fifo_val[wr_ptr] <= reg_w_reg_val;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_overflow <= 1'b0;
    end else if (drop) begin
      wb_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // GPR file; committed from the FIFO head
  // ---------------------------------------------------------------------------
  logic [31:0] gpr [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= '0;
      end
    end else if (pop && (fifo_idx[rd_ptr] != 5'd0)) begin
      gpr[fifo_idx[rd_ptr]] <= fifo_val[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with bypass
  // ---------------------------------------------------------------------------
  // Walk the occupied window from oldest to youngest; a later match
  // overrides an earlier one, so the youngest pending write wins. Walking
  // by age offset from rd_ptr handles wrap-around without any special case.
  function automatic logic [31:0] read_port(input logic [4:0] idx);
    logic [31:0]   v;
    logic [AW-1:0] slot;
    v    = gpr[idx];
    slot = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + AW'(k);
      if (((AW+1)'(k) < count) && (fifo_idx[slot] == idx)) begin
        v = fifo_val[slot];
      end
    end
    if (idx == 5'd0) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    reg_rs1_val = read_port(reg_rs1);
    reg_rs2_val = read_port(reg_rs2);
  end

  // ---------------------------------------------------------------------------
  // PC; independent of the FIFO and of wb_hold
  // ---------------------------------------------------------------------------
  logic [31:0] redirect_pc;

  // Only bit 0 is cleared; a bit-1 target is still taken and merely reported.
  assign redirect_pc = reg_pc_w_val & ~32'h1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_pc_val  <= RESET_PC;
      pc_misalign <= 1'b0;
    end else if (reg_pc_w_op) begin
      reg_pc_val  <= redirect_pc;
      pc_misalign <= reg_pc_w_val[1];
    end else begin
      if (pc_adv) begin
        reg_pc_val <= reg_pc_val + 32'd4;
      end
      pc_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_wb_commit.sv
module tb_reg_wb_commit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_w_op = 1'b0;
  logic [4:0]  reg_w_reg_idx = '0;
  logic [31:0] reg_w_reg_val = '0;
  logic        reg_pc_w_op = 1'b0;
  logic [31:0] reg_pc_w_val = '0;
  logic        pc_adv = 1'b0;
  logic        wb_hold = 1'b0;
  logic        wb_ready;
  logic [4:0]  reg_rs1 = '0;
  logic [4:0]  reg_rs2 = '0;
  logic [31:0] reg_rs1_val;
  logic [31:0] reg_rs2_val;
  logic [31:0] reg_pc_val;
  logic        wb_busy;
  logic        wb_overflow;
  logic        pc_misalign;

  always #5 clk = ~clk;

  reg_wb_commit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_w_op      (reg_w_op),
    .reg_w_reg_idx (reg_w_reg_idx),
    .reg_w_reg_val (reg_w_reg_val),
    .reg_pc_w_op   (reg_pc_w_op),
    .reg_pc_w_val  (reg_pc_w_val),
    .pc_adv        (pc_adv),
    .wb_hold       (wb_hold),
    .wb_ready      (wb_ready),
    .reg_rs1       (reg_rs1),
    .reg_rs2       (reg_rs2),
    .reg_rs1_val   (reg_rs1_val),
    .reg_rs2_val   (reg_rs2_val),
    .reg_pc_val    (reg_pc_val),
    .wb_busy       (wb_busy),
    .wb_overflow   (wb_overflow),
    .pc_misalign   (pc_misalign)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;
  logic        m_ovf;
  logic        m_mis;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  function automatic void m_reset();
    q.delete();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_pc  = 32'h0;
    m_ovf = 1'b0;
    m_mis = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] i);
    if (i == 5'd0) return 32'h0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].idx == i) return q[k].val;
    end
    return m_gpr[i];
  endfunction

  always @(negedge rst_n) m_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      bit   ready;
      bit   do_push;
      ent_t e;
      ready   = (q.size() != DEPTH);
      do_push = 0;
      if (reg_w_op) begin
        if (!ready) m_ovf = 1'b1;
        else if (reg_w_reg_idx != 5'd0) do_push = 1;
      end
      if (!wb_hold && q.size() != 0) begin
        e = q.pop_front();
        m_gpr[e.idx] = e.val;
      end
      if (do_push) begin
        e.idx = reg_w_reg_idx;
        e.val = reg_w_reg_val;
        q.push_back(e);
      end
      if (reg_pc_w_op) begin
        m_pc  = {reg_pc_w_val[31:1], 1'b0};
        m_mis = reg_pc_w_val[1];
      end else begin
        if (pc_adv) m_pc = m_pc + 32'd4;
        m_mis = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk ("rs1_val",  reg_rs1_val, m_read(reg_rs1));
      chk ("rs2_val",  reg_rs2_val, m_read(reg_rs2));
      chk ("pc_val",   reg_pc_val,  m_pc);
      chk1("ready",    wb_ready,    q.size() != DEPTH);
      chk1("busy",     wb_busy,     q.size() != 0);
      chk1("overflow", wb_overflow, m_ovf);
      chk1("misalign", pc_misalign, m_mis);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic w, input logic [4:0] idx, input logic [31:0] val,
                       input logic pop_pc, input logic [31:0] pcv, input logic adv,
                       input logic hold);
    @(posedge clk);
    #1;
    reg_w_op      = w;
    reg_w_reg_idx = idx;
    reg_w_reg_val = val;
    reg_pc_w_op   = pop_pc;
    reg_pc_w_val  = pcv;
    pc_adv        = adv;
    wb_hold       = hold;
  endtask

  task automatic idle(input logic hold);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, hold);
  endtask

  task automatic wait_chk();
    @(negedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // 1. reset state
    chk ("reset_pc",       reg_pc_val,  32'h0);
    chk1("reset_ready",    wb_ready,    1'b1);
    chk1("reset_busy",     wb_busy,     1'b0);
    chk1("reset_overflow", wb_overflow, 1'b0);
    chk1("reset_misalign", pc_misalign, 1'b0);
    for (int i = 0; i < 32; i++) begin
      reg_rs1 = 5'(i);
      #1;
      chk("reset_rs1", reg_rs1_val, 32'h0);
    end
    chk_en = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2. JALR: GPR write and redirect on the same edge
    reg_rs1 = 5'd1;
    reg_rs2 = 5'd2;
    drive(1'b1, 5'd1, 32'h104, 1'b1, 32'h201, 1'b0, 1'b0);
    idle(1'b0);
    wait_chk();
    chk ("jalr_pc",       reg_pc_val,  32'h200);
    chk ("jalr_bypass",   reg_rs1_val, 32'h104);
    chk1("jalr_busy",     wb_busy,     1'b1);
    chk1("jalr_misalign", pc_misalign, 1'b0);
    idle(1'b0);
    wait_chk();
    chk ("jalr_gpr",      reg_rs1_val, 32'h104);
    chk1("jalr_drained",  wb_busy,     1'b0);

    // 3. hold, youngest-wins bypass, full, overflow, in-order drain
    reg_rs1 = 5'd5;
    reg_rs2 = 5'd6;
    drive(1'b1, 5'd5, 32'hA, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 5'd5, 32'hB, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    wait_chk();
    chk ("hold_youngest", reg_rs1_val, 32'hB);
    chk1("hold_ready",    wb_ready,    1'b1);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 5'd7, 32'h77, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    wait_chk();
    chk1("full_ready",    wb_ready,    1'b0);
    drive(1'b1, 5'd5, 32'hC, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    wait_chk();
    chk1("ovf_set",       wb_overflow, 1'b1);
    chk ("ovf_dropped",   reg_rs1_val, 32'hB);
    chk ("ovf_rs2",       reg_rs2_val, 32'h66);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);
    wait_chk();
    chk1("drain_busy",    wb_busy,     1'b0);
    chk ("drain_x5",      reg_rs1_val, 32'hB);
    chk ("drain_x6",      reg_rs2_val, 32'h66);
    chk1("ovf_sticky",    wb_overflow, 1'b1);

    // 4. x0 write is accepted but never stored
    reg_rs1 = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    wait_chk();
    chk1("x0_busy", wb_busy,     1'b0);
    chk ("x0_read", reg_rs1_val, 32'h0);

    // 5. PC wrap and misaligned redirect
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    wait_chk();
    chk ("pc_top",    reg_pc_val, 32'hFFFF_FFFC);
    idle(1'b0);
    wait_chk();
    chk ("pc_wrap",   reg_pc_val, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h6, 1'b1, 1'b0);
    idle(1'b0);
    wait_chk();
    chk ("pc_mis",    reg_pc_val,  32'h6);
    chk1("mis_pulse", pc_misalign, 1'b1);
    idle(1'b0);
    wait_chk();
    chk1("mis_clear", pc_misalign, 1'b0);
    chk ("pc_hold",   reg_pc_val,  32'h6);

    // 6. asynchronous reset with pending entries
    reg_rs1 = 5'd1;
    reg_rs2 = 5'd2;
    drive(1'b1, 5'd1, 32'h11, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 5'd2, 32'h22, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    wait_chk();
    chk ("pend_rs1",  reg_rs1_val, 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_busy",  wb_busy,     1'b0);
    chk1("arst_ready", wb_ready,    1'b1);
    chk ("arst_rs1",   reg_rs1_val, 32'h0);
    chk ("arst_rs2",   reg_rs2_val, 32'h0);
    chk ("arst_pc",    reg_pc_val,  32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0);
    reg_rs2 = 5'd3;
    wait_chk();
    chk ("post_rs1", reg_rs1_val, 32'h0);
    chk ("post_rs3", reg_rs2_val, 32'h0);
    chk1("post_ovf", wb_overflow, 1'b0);

    // randomized phase, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic hold;
      if ((i % 200) < 60) hold = ($urandom_range(0, 9) != 0);
      else                hold = ($urandom_range(0, 3) == 0);
      reg_rs1 = 5'($urandom_range(0, 7));
      reg_rs2 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 7) == 0), $urandom(), 1'($urandom_range(0, 1)), hold);
    end
    idle(1'b0);
    wait_chk();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
